// File: rtl/output_sequencer_if.sv
// Handshake bundle for output_sequencer: CDF RAM read port, equalizer feed/return and LUT write port.
// OUTSEQ_DRAIN_TIMEOUT_EN adds the sticky timeout flag.
interface output_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 20,
  parameter int RES_W  = 28
);
  logic              go;
  logic              busy;
  logic              done;
  logic              cdf_rd;
  logic [ADDR_W-1:0] cdf_addr;
  logic [DATA_W-1:0] cdf_data;
  logic [DATA_W-1:0] cdf_min;
  logic              pipe_start;
  logic [DATA_W-1:0] pipe_data;
  logic              pipe_valid;
  logic [RES_W-1:0]  pipe_result;
  logic              lut_we;
  logic [ADDR_W-1:0] lut_addr;
  logic [RES_W-1:0]  lut_data;
`ifdef OUTSEQ_DRAIN_TIMEOUT_EN
  logic              timeout;

  modport master (
    output go, cdf_data, pipe_valid, pipe_result,
    input  busy, done, cdf_rd, cdf_addr, cdf_min, pipe_start, pipe_data,
           lut_we, lut_addr, lut_data, timeout
  );

  modport slave (
    input  go, cdf_data, pipe_valid, pipe_result,
    output busy, done, cdf_rd, cdf_addr, cdf_min, pipe_start, pipe_data,
           lut_we, lut_addr, lut_data, timeout
  );
`else
  modport master (
    output go, cdf_data, pipe_valid, pipe_result,
    input  busy, done, cdf_rd, cdf_addr, cdf_min, pipe_start, pipe_data,
           lut_we, lut_addr, lut_data
  );

  modport slave (
    input  go, cdf_data, pipe_valid, pipe_result,
    output busy, done, cdf_rd, cdf_addr, cdf_min, pipe_start, pipe_data,
           lut_we, lut_addr, lut_data
  );
`endif
endinterface

// File: rtl/output_sequencer.sv
// Scans the CDF for its minimum nonzero entry, streams clamped CDF words through the equalizer
// and writes the returned results into the LUT. OUTSEQ_DRAIN_TIMEOUT_EN enables a DRAIN watchdog.
module output_sequencer #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 20,
  parameter int RES_W  = 28
) (
  input  logic               clock,
  input  logic               reset,
  output_sequencer_if.slave  bus
);

  localparam logic [ADDR_W:0] CNT_N    = (ADDR_W+1)'(1 << ADDR_W);
  localparam logic [ADDR_W:0] CNT_LAST = CNT_N - 1'b1;
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);

  typedef enum logic [2:0] {IDLE, SCAN, ISSUE, DRAIN, FINISH} state_t;

  state_t state, state_nxt;

  logic              cdf_rd_q;
  logic [ADDR_W-1:0] cdf_addr_q;
  logic              rd_is_iss;
  logic              ret_scan;
  logic              ret_iss;
  logic [ADDR_W:0]   rd_cnt;
  logic [ADDR_W:0]   ret_cnt;
  logic [DATA_W-1:0] cdf_min_q;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W:0]   wr_cnt;
  logic              lut_we_q;
  logic [ADDR_W-1:0] lut_addr_q;
  logic [RES_W-1:0]  lut_data_q;

  logic              scan_hit;
  logic              scan_last;
  logic              iss_last;
  logic              write_fire;
  logic              write_last;
  logic              drain_expire;
  logic [DATA_W-1:0] clamp;

  // Returned data is tagged by the kind of read that produced it, so a SCAN read still
  // in flight when SCAN exits early is never mistaken for an ISSUE return.
  assign scan_hit   = (state == SCAN) && ret_scan && (bus.cdf_data != '0);
  assign scan_last  = (state == SCAN) && ret_scan && (ret_cnt == CNT_LAST);
  assign iss_last   = (state == ISSUE) && (rd_cnt == CNT_N);
  assign write_fire = bus.pipe_valid && ((state == ISSUE) || (state == DRAIN));
  assign write_last = write_fire && (wr_cnt == CNT_LAST);
  assign clamp      = (bus.cdf_data > cdf_min_q) ? bus.cdf_data : cdf_min_q;

`ifdef OUTSEQ_DRAIN_TIMEOUT_EN
  logic [3:0] idle_cnt;
  logic       timeout_q;

  assign drain_expire = (state == DRAIN) && !bus.pipe_valid && (idle_cnt == 4'd15);
  assign bus.timeout  = timeout_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idle_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state == IDLE && bus.go) begin
        timeout_q <= 1'b0;
      end else if (drain_expire) begin
        timeout_q <= 1'b1;
      end
      if (state != DRAIN || bus.pipe_valid) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + 4'd1;
      end
    end
  end
`else
  assign drain_expire = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.go) state_nxt = SCAN;
      SCAN:    if (scan_hit || scan_last) state_nxt = ISSUE;
      ISSUE:   if (iss_last) state_nxt = DRAIN;
      DRAIN:   if (write_last || drain_expire) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cdf_rd_q   <= 1'b0;
      cdf_addr_q <= '0;
      rd_is_iss  <= 1'b0;
      ret_scan   <= 1'b0;
      ret_iss    <= 1'b0;
      rd_cnt     <= '0;
      ret_cnt    <= '0;
      cdf_min_q  <= '0;
      wr_ptr     <= '0;
      wr_cnt     <= '0;
      lut_we_q   <= 1'b0;
      lut_addr_q <= '0;
      lut_data_q <= '0;
    end else begin
      ret_scan <= cdf_rd_q && !rd_is_iss;
      ret_iss  <= cdf_rd_q && rd_is_iss;
      lut_we_q <= 1'b0;
      case (state)
        IDLE: begin
          cdf_rd_q <= 1'b0;
          if (bus.go) begin
            cdf_rd_q   <= 1'b1;
            cdf_addr_q <= '0;
            rd_is_iss  <= 1'b0;
            rd_cnt     <= CNT_ONE;
            ret_cnt    <= '0;
            cdf_min_q  <= '0;
            wr_ptr     <= '0;
            wr_cnt     <= '0;
          end
        end
        SCAN: begin
          if (ret_scan) ret_cnt <= ret_cnt + CNT_ONE;
          if (scan_hit) cdf_min_q <= bus.cdf_data;
          if (scan_hit || scan_last) begin
            cdf_rd_q   <= 1'b1;
            cdf_addr_q <= '0;
            rd_is_iss  <= 1'b1;
            rd_cnt     <= CNT_ONE;
          end else if (rd_cnt != CNT_N) begin
            cdf_rd_q   <= 1'b1;
            cdf_addr_q <= cdf_addr_q + 1'b1;
            rd_cnt     <= rd_cnt + CNT_ONE;
          end else begin
            cdf_rd_q <= 1'b0;
          end
        end
        ISSUE: begin
          if (iss_last) begin
            cdf_rd_q <= 1'b0;
          end else begin
            cdf_rd_q   <= 1'b1;
            cdf_addr_q <= cdf_addr_q + 1'b1;
            rd_cnt     <= rd_cnt + CNT_ONE;
          end
        end
        default: cdf_rd_q <= 1'b0;
      endcase
      if (write_fire) begin
        lut_we_q   <= 1'b1;
        lut_addr_q <= wr_ptr;
        lut_data_q <= bus.pipe_result;
        wr_ptr     <= wr_ptr + 1'b1;
        wr_cnt     <= wr_cnt + CNT_ONE;
      end
    end
  end

  assign bus.busy       = (state == SCAN) || (state == ISSUE) || (state == DRAIN);
  assign bus.done       = (state == FINISH);
  assign bus.cdf_rd     = cdf_rd_q;
  assign bus.cdf_addr   = cdf_addr_q;
  assign bus.cdf_min    = cdf_min_q;
  assign bus.pipe_start = ret_iss;
  assign bus.pipe_data  = ret_iss ? clamp : '0;
  assign bus.lut_we     = lut_we_q;
  assign bus.lut_addr   = lut_addr_q;
  assign bus.lut_data   = lut_data_q;

endmodule

// File: doc/output_sequencer.md
OUTPUT_SEQUENCER -- requirements
Module: output_sequencer

Interface
REQ-001 Parameter ADDR_W, default 8, gray-level address width (2^ADDR_W CDF entries).
REQ-002 Parameter DATA_W, default 20, CDF word width.
REQ-003 Parameter RES_W, default 28, equalizer result width.
REQ-004 clock  in  1  sole clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 go  in  1  single-cycle start request.
REQ-007 busy  out  1  high from accepted go until done.
REQ-008 done  out  1  one-cycle pulse when the LUT is complete.
REQ-009 cdf_rd  out  1  CDF RAM read strobe.
REQ-010 cdf_addr  out  ADDR_W  CDF RAM read address.
REQ-011 cdf_data  in  DATA_W  CDF RAM read data, valid exactly one cycle after cdf_rd.
REQ-012 cdf_min  out  DATA_W  captured minimum nonzero CDF value; static while busy after SCAN.
REQ-013 pipe_start  out  1  drives equalizer StartIn.
REQ-014 pipe_data  out  DATA_W  drives equalizer DataIn.
REQ-015 pipe_valid  in  1  equalizer StartOut.
REQ-016 pipe_result  in  RES_W  equalizer DataOut.
REQ-017 lut_we, lut_addr (ADDR_W), lut_data (RES_W)  out  LUT write port.

Function
REQ-018 FSM states SHALL be IDLE, SCAN, ISSUE, DRAIN, FINISH.
REQ-019 IDLE: go=1 -> SCAN, read address counter cleared to 0, cdf_min cleared to 0; go while busy SHALL be ignored.
REQ-020 SCAN: cdf_rd=1 each cycle with cdf_addr incrementing from 0; the first returned cdf_data != 0 SHALL be latched into cdf_min and SCAN ends (early exit), discarding any in-flight read.
REQ-021 SCAN with all 2^ADDR_W entries zero SHALL leave cdf_min=0 and proceed to ISSUE after the last return.
REQ-022 ISSUE: cdf_addr restarts at 0, cdf_rd=1 each cycle for 2^ADDR_W cycles; one cycle after each read pipe_start=1 and pipe_data = max(cdf_data, cdf_min).
REQ-023 Clamp of REQ-022 SHALL guarantee pipe_data >= cdf_min so entries below the minimum yield result 0.
REQ-024 After the last issue -> DRAIN; pipe_start SHALL be 0 and pipe_data 0 whenever not issuing.
REQ-025 Each pipe_valid=1 cycle SHALL produce lut_we=1, lut_data=pipe_result, lut_addr=write counter, then increment the write counter (registered, one cycle after pipe_valid).
REQ-026 Write counter SHALL count independently of issue; results arriving during ISSUE SHALL be written.
REQ-027 When 2^ADDR_W writes have completed -> FINISH; FINISH SHALL pulse done for one cycle, deassert busy, return to IDLE.
REQ-028 Address counters SHALL wrap silently at 2^ADDR_W; termination is by separate count, not wrap.
REQ-029 pipe_valid in IDLE or SCAN SHALL be ignored (no LUT write).
REQ-030 Minimum go-to-done latency with early exit at entry k and 3-cycle equalizer: (k+2)+(2^ADDR_W)+4 cycles.

Reset
REQ-031 reset=1 SHALL immediately force IDLE and all outputs to 0 (busy, done, cdf_rd, cdf_addr, cdf_min, pipe_start, pipe_data, lut_we, lut_addr, lut_data), including mid-operation; a partially written LUT is not cleared.
REQ-032 Operation SHALL resume only on a go after reset deasserts.

Configuration
REQ-033 Macro OUTSEQ_DRAIN_TIMEOUT_EN defined: an extra output timeout (1 bit) SHALL be present; in DRAIN, 16 consecutive cycles with no pipe_valid SHALL set timeout (sticky until next go or reset) and go to FINISH.
REQ-034 Macro undefined: no timeout port; DRAIN waits indefinitely for all results.

Verification
REQ-035 CDF[i]=i+1 for all i, go -> cdf_min=1, 256 pipe_start pulses, lut_data[i]=(i)*255 per model, one done pulse.
REQ-036 CDF[0..9]=0, CDF[10..255]=100 -> cdf_min=100, SCAN ends after entry 10, lut_data[0..255]=0, done.
REQ-037 All CDF=0 -> cdf_min=0, 256 issues with pipe_data=0, 256 LUT writes of 0.
REQ-038 reset asserted at ISSUE address 50 -> all outputs 0 same cycle, busy=0; subsequent go completes normally.
REQ-039 go pulsed again during ISSUE -> ignored, exactly 256 LUT writes, single done.
REQ-040 With OUTSEQ_DRAIN_TIMEOUT_EN, equalizer stub drops last result -> timeout=1 16 cycles into DRAIN, done pulses, 255 LUT writes.
